// File: rtl/memory_bus_master_pkg.sv
// Shared types and defaults for the memory bus initiator and the memory_unit it drives.
// Widths here are the integration defaults used on both sides of the bus.
package memory_bus_master_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 32;
   localparam int unsigned ADDR_WIDTH_DEF = 10;
   localparam int unsigned CNT_WIDTH      = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   typedef logic [CNT_WIDTH-1:0] cnt_t;

   function automatic logic is_bus_state(state_t s);
      return (s == ST_WRITE) || (s == ST_READ);
   endfunction

endpackage

// File: rtl/memory_bus_master_if.sv
// Request/response handshake plus memory bus controls between CPU, initiator and memory.
// The bidirectional data lines stay a plain inout on the initiator.
interface memory_bus_master_if
   import memory_bus_master_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_enable;
   logic                  mem_we;
   logic                  mem_re;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output mem_addr, mem_enable, mem_we, mem_re
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  mem_addr, mem_enable, mem_we, mem_re
   );

endinterface

// File: rtl/bus_tristate.sv
// Drives a shared bidirectional bus only while output-enabled, otherwise releases it.
module bus_tristate #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  i_oe,
   input  logic [DATA_WIDTH-1:0] i_din,
   inout  wire  [DATA_WIDTH-1:0] io_pad
);

   assign io_pad = i_oe ? i_din : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/memory_bus_master.sv
// Single-outstanding load/store initiator for the shared single-port memory bus.
//   state    | meaning
//   ST_IDLE  | ready for a request
//   ST_WRITE | one bus cycle driving store data, memory commits at its end
//   ST_READ  | re held RD_WAIT+1 cycles, data sampled on the last edge
//   ST_RESP  | response held until the consumer takes it
module memory_bus_master
   import memory_bus_master_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned WORDS      = 1024,
   parameter int unsigned RD_WAIT    = 0
) (
   input  logic                   i_clock,
   input  logic                   i_rst,
   memory_bus_master_if.master    io_bus,
   inout  wire  [DATA_WIDTH-1:0]  io_mem_data
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   cnt_t                  r_cnt;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_rsp_err;
   logic                  r_mem_enable;
   logic                  r_mem_we;
   logic                  r_mem_re;
   logic                  w_enable_nxt;
   logic                  w_we_nxt;
   logic                  w_re_nxt;
   logic                  w_accept;
   logic                  w_addr_bad;

   assign w_accept   = (r_state == ST_IDLE) && io_bus.req_valid;
   assign w_addr_bad = 32'(io_bus.req_addr) >= WORDS;

   // Bus controls are registered alongside the state so they never glitch.
   always_ff @(posedge i_clock or negedge i_rst) begin
      if (!i_rst) begin
         r_state      <= ST_IDLE;
         r_mem_enable <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_re     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_mem_enable <= w_enable_nxt;
         r_mem_we     <= w_we_nxt;
         r_mem_re     <= w_re_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (io_bus.req_valid) begin
               if (w_addr_bad)         w_state_nxt = ST_RESP;
               else if (io_bus.req_we) w_state_nxt = ST_WRITE;
               else                    w_state_nxt = ST_READ;
            end
         end
         ST_WRITE: w_state_nxt = ST_RESP;
         ST_READ:  if (r_cnt == '0) w_state_nxt = ST_RESP;
         ST_RESP:  if (io_bus.rsp_ready) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_enable_nxt = is_bus_state(w_state_nxt);
      w_we_nxt     = (w_state_nxt == ST_WRITE);
      w_re_nxt     = (w_state_nxt == ST_READ);
   end

   always_ff @(posedge i_clock or negedge i_rst) begin
      if (!i_rst) begin
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cnt       <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else if (w_accept) begin
         r_addr      <= io_bus.req_addr;
         r_wdata     <= io_bus.req_wdata;
         r_cnt       <= CNT_WIDTH'(RD_WAIT);
         r_rsp_rdata <= '0;
         r_rsp_err   <= w_addr_bad;
      end else if (r_state == ST_READ) begin
         if (r_cnt == '0) r_rsp_rdata <= io_mem_data;
         else             r_cnt       <= r_cnt - cnt_t'(1);
      end
   end

   bus_tristate #(.DATA_WIDTH(DATA_WIDTH)) u_data_drv (
      .i_oe   (r_mem_we),
      .i_din  (r_wdata),
      .io_pad (io_mem_data)
   );

   assign io_bus.req_ready  = (r_state == ST_IDLE);
   assign io_bus.rsp_valid  = (r_state == ST_RESP);
   assign io_bus.rsp_rdata  = r_rsp_rdata;
   assign io_bus.rsp_err    = r_rsp_err;
   assign io_bus.mem_addr   = r_addr;
   assign io_bus.mem_enable = r_mem_enable;
   assign io_bus.mem_we     = r_mem_we;
   assign io_bus.mem_re     = r_mem_re;

   // The data driver enable is r_mem_we itself, so it can only drive during a write.
   a_we_re_exclusive: assert property (@(posedge i_clock) disable iff (!i_rst)
      !(r_mem_we && r_mem_re));
   a_enable_matches: assert property (@(posedge i_clock) disable iff (!i_rst)
      r_mem_enable == (r_mem_we || r_mem_re));

endmodule
